bram_port_initiator: RTL and testbench



---
 rtl/bram_initiator_pkg.sv | 18 +
 rtl/bram_resp_fifo.sv | 56 +++++
 rtl/bram_port_initiator.sv | 111 +++++++++++
 tb/tb_bram_port_initiator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_initiator_pkg.sv
// Shared types and constants for the BRAM port initiator and its response FIFO.
package bram_initiator_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } initState_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_RESP_DEPTH = 3;

    // Width needed to count 0..depth outstanding responses.
    function automatic int creditWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Small register FIFO holding read responses until the client takes them.
module bram_resp_fifo
    import bram_initiator_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_RESP_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic [creditWidth(DEPTH)-1:0] count,
    output logic                          empty
);

    localparam int CW = creditWidth(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    cnt;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (!push && pop) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= din;
    end

    assign dout  = mem[rdPtr];
    assign count = cnt;
    assign empty = (cnt == '0);

    // Credit gating upstream must make both of these unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && cnt == CW'(DEPTH)));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && cnt == '0));

endmodule

// File: rtl/bram_port_initiator.sv
// Drives one BRAM port from a request channel, zero-fills the RAM after reset,
// and returns read data in order through a credit-limited response FIFO.
module bram_port_initiator
    import bram_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int RESP_DEPTH    = DEF_RESP_DEPTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_vld,
    output logic                  req_rd,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_vld,
    input  logic                  resp_rd,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_en,
    output logic                  ram_we
);

    // Handshake: a request transfers on a clock edge where req_vld && req_rd;
    // a response transfers where resp_vld && resp_rd. req_rd depends only on
    // registered state, never on req_vld or resp_rd.

    localparam int CW = creditWidth(RESP_DEPTH);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(RESP_DEPTH);

    initState_t            state;
    initState_t            stateNext;
    logic                  armed;
    logic [ADDR_WIDTH-1:0] initCnt;
    logic                  inflight;
    logic                  accept;
    logic                  live;
    logic [CW-1:0]         fifoCount;
    logic                  fifoEmpty;
    logic [CW:0]           credUsed;

    // armed keeps the first cycle after reset release quiet on every output.
    assign live     = rst_n && armed;
    assign credUsed = {1'b0, fifoCount} + (CW + 1)'(inflight);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT_ON_RESET ? INIT : RUN;
            armed    <= 1'b0;
            initCnt  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= stateNext;
            armed    <= 1'b1;
            inflight <= accept && !req_we;
            if (armed && state == INIT) initCnt <= initCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        req_rd    = 1'b0;
        init_done = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_addr;
        ram_din   = req_data;
        case (state)
            INIT: begin
                if (live) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = initCnt;
                    ram_din  = '0;
                    if (initCnt == '1) stateNext = RUN;
                end
            end
            RUN: begin
                init_done = live;
                // Writes are gated by the same credit rule to keep ordering trivial.
                req_rd    = live && (credUsed < DEPTH_L);
                accept    = req_vld && req_rd;
                ram_en    = accept;
                ram_we    = accept && req_we;
            end
        endcase
    end

    assign resp_vld = rst_n && !fifoEmpty;

    bram_resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) respFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (ram_dout),
        .pop   (resp_vld && resp_rd),
        .dout  (resp_data),
        .count (fifoCount),
        .empty (fifoEmpty)
    );

endmodule

// File: tb/tb_bram_port_initiator.sv
// Randomized scoreboard bench for bram_port_initiator with a write-first BRAM stub.
module tb_bram_port_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req_addr;
    logic        req_we;
    logic [63:0] req_data;
    logic        req_vld;
    logic        req_rd;
    logic [63:0] resp_data;
    logic        resp_vld;
    logic        resp_rd;
    logic        init_done;
    logic [7:0]  ram_addr;
    logic [63:0] ram_din;
    logic [63:0] ram_dout;
    logic        ram_en;
    logic        ram_we;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    bit lat_exact = 1'b1;
    bit rand_rd   = 1'b0;

    logic [63:0] model_mem [256];
    logic [63:0] ram_mem [256];
    logic [63:0] exp_q [$];
    int          acc_q [$];
    int          pop_cyc_q [$];

    bram_port_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_data  (req_data),
        .req_vld   (req_vld),
        .req_rd    (req_rd),
        .resp_data (resp_data),
        .resp_vld  (resp_vld),
        .resp_rd   (resp_rd),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_en    (ram_en),
        .ram_we    (ram_we)
    );

    // clock / cycle counter / RAM stub
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = {$urandom, $urandom};
        ram_dout = '0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_din;
                ram_dout <= ram_din;
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rd) begin
            #1 resp_rd = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard whenever a response transfers
    always @(negedge clk) begin
        if (rst_n && resp_vld && resp_rd) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_extra act=%h exp=none (cycle %0d)", resp_data, cyc);
            end else begin
                logic [63:0] e;
                int a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("resp_data", resp_data, e);
                if (lat_exact) check("resp_lat", 64'(cyc - a), 64'd2);
                else           check("resp_lat_min", 64'((cyc - a) >= 2), 64'd1);
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    // driver tasks: all start and end one time unit after a rising edge
    task automatic send(input logic we, input logic [7:0] addr, input logic [63:0] data);
        bit acc;
        acc = 1'b0;
        req_vld = 1'b1; req_we = we; req_addr = addr; req_data = data;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (req_rd) begin
                acc = 1'b1;
                last_acc = cyc;
                if (we) model_mem[addr] = data;
                else begin
                    exp_q.push_back(model_mem[addr]);
                    acc_q.push_back(cyc);
                end
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=no_accept exp=accept addr=%h", addr);
        end
    endtask

    task automatic idle();
        req_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        req_vld = 1'b0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req_vld = 1'b0;
        @(negedge clk);
        check("rst_quiet", {59'd0, ram_en, ram_we, req_rd, init_done, resp_vld}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
    endtask

    // Zero-fill must hit 0..255 in order, one write per cycle, then RUN.
    task automatic run_init(input int abort_at);
        @(negedge clk);
        check("init_cycle0", {59'd0, ram_en, ram_we, req_rd, init_done, resp_vld}, 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            check("init_ctl", {60'd0, ram_en, ram_we, init_done, req_rd}, 64'b1100);
            check("init_addr", 64'(ram_addr), 64'(i));
            check("init_din", ram_din, 64'd0);
            @(posedge clk); #1;
            if (i == abort_at) return;
        end
        @(negedge clk);
        check("init_done", {61'd0, init_done, req_rd, ram_en}, 64'b110);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
    endtask

    initial begin
        int prev;
        rst_n = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        resp_rd = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        pulse_reset();
        run_init(-1);

        send(1'b0, 8'h7F, '0);
        wait_drain();

        send(1'b1, 8'hFF, 64'h5);
        send(1'b0, 8'hFF, '0);
        send(1'b0, 8'h00, '0);
        wait_drain();

        send(1'b1, 8'h10, 64'hDEADBEEF_00000001);
        send(1'b0, 8'h10, '0);
        wait_drain();

        // 16 back-to-back reads with resp_rd held high
        for (int i = 0; i < 16; i++) send(1'b1, 8'(i), {$urandom, $urandom});
        pop_cyc_q.delete();
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 8'(i), '0);
            if (i > 0) check("b2b_acc", 64'(last_acc - prev), 64'd1);
            prev = last_acc;
        end
        wait_drain();
        check("b2b_count", 64'(pop_cyc_q.size()), 64'd16);
        for (int i = 1; i < pop_cyc_q.size(); i++)
            check("b2b_resp", 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'd1);

        // backpressure: only RESP_DEPTH reads may be outstanding
        lat_exact = 1'b0;
        resp_rd = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 8'(i + 4), '0);
        req_vld = 1'b1; req_we = 1'b0; req_addr = 8'h07;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req_rd", 64'(req_rd), 64'd0);
            check("bp_resp_vld", 64'(resp_vld), 64'd1);
            @(posedge clk); #1;
        end
        check("bp_pending", 64'(exp_q.size()), 64'd3);
        resp_rd = 1'b1;
        send(1'b0, 8'h07, '0);
        wait_drain();

        // random mix with random response backpressure
        rand_rd = 1'b1;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), {$urandom, $urandom});
        end
        req_vld = 1'b0;
        rand_rd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resp_rd = 1'b1;
        wait_drain();
        lat_exact = 1'b1;

        // reset during INIT at cnt=100, then during a pending read
        pulse_reset();
        run_init(99);
        pulse_reset();
        run_init(-1);
        send(1'b1, 8'h20, 64'h1234_5678_9ABC_DEF0);
        send(1'b0, 8'h20, '0);
        pulse_reset();
        run_init(-1);
        send(1'b0, 8'h20, '0);
        wait_drain();
        repeat (5) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
